// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - load/store unit bridging the memory stage to a word-addressed, byte-enabled RAM/bus
module data_mem_ctrl #(
  parameter int ADDR_W  = 30,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [31:0]       load_data,
  output logic              misalign_err,
  output logic              timeout_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state, state_nxt;
  logic              r_we, r_uns, r_tmo;
  logic [3:0]        r_be;
  logic [1:0]        r_size, r_off;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [CW-1:0]     cnt;

  logic              misalign, tmo_hit;
  logic [3:0]        req_be;
  logic [31:0]       req_wd, lane, ext;

  always_comb begin
    misalign = (req_size == 2'b11) ||
               (req_size == 2'b01 && req_addr[0]) ||
               (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    tmo_hit  = (TIMEOUT != 0) && (cnt == CNT_LAST);
    req_be   = 4'b1111;
    req_wd   = req_wdata;
    case (req_size)
      2'b00: begin
        req_be = 4'b0001 << req_addr[1:0];
        req_wd = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_be = req_addr[1] ? 4'b1100 : 4'b0011;
        req_wd = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane select uses the latched offset; half accesses only ever see offsets 0 or 2.
  always_comb begin
    lane = mem_rdata >> {r_off, 3'b000};
    case (r_size)
      2'b00:   ext = r_uns ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'b01:   ext = r_uns ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = misalign ? ERR : BUSY;
      BUSY: begin
        if (mem_ready)    state_nxt = DONE;
        else if (tmo_hit) state_nxt = ERR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_we      <= 1'b0;
      r_uns     <= 1'b0;
      r_tmo     <= 1'b0;
      r_be      <= 4'b0;
      r_size    <= 2'b0;
      r_off     <= 2'b0;
      r_addr    <= '0;
      r_wdata   <= 32'b0;
      cnt       <= '0;
      load_data <= 32'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          if (misalign) begin
            r_tmo     <= 1'b0;
            load_data <= 32'b0;
          end else begin
            r_we    <= req_write;
            r_uns   <= req_unsigned;
            r_be    <= req_be;
            r_size  <= req_size;
            r_off   <= req_addr[1:0];
            r_addr  <= req_addr[ADDR_W+1:2];
            r_wdata <= req_wd;
            cnt     <= '0;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            if (!r_we) load_data <= ext;
          end else if (tmo_hit) begin
            r_tmo     <= 1'b1;
            load_data <= 32'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Stall is gated by reset so a held req_valid cannot leak through while in reset.
  always_comb begin
    stall        = reset && ((state == IDLE && req_valid) || state == BUSY);
    resp_valid   = (state == DONE) || (state == ERR);
    misalign_err = (state == ERR) && !r_tmo;
    timeout_err  = (state == ERR) && r_tmo;
    mem_en       = (state == BUSY);
    mem_we       = mem_en && r_we;
    mem_be       = mem_en ? r_be : 4'b0000;
    mem_addr     = r_addr;
    mem_wdata    = r_wdata;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed and randomized checks of data_mem_ctrl against a behavioural model
module tb_data_mem_ctrl;
  localparam int TMO = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'b0, req_wdata = 32'b0;
  logic [31:0] mem_rdata = 32'b0;
  logic        mem_ready = 1'b0;
  logic        stall, resp_valid, misalign_err, timeout_err, mem_en, mem_we;
  logic [31:0] load_data, mem_wdata;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_ld = 32'b0;

  data_mem_ctrl #(.ADDR_W(30), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .resp_valid(resp_valid), .load_data(load_data),
    .misalign_err(misalign_err), .timeout_err(timeout_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(logic [31:0] rd, logic [1:0] off,
                                             logic [1:0] sz, logic uns);
    logic [31:0] v;
    v = rd >> (8 * off);
    if (sz == 2'd2) return rd;
    if (sz == 2'd0) begin
      v = v & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else begin
      v = v & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_be(logic [1:0] sz, logic [1:0] off);
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wd(logic [1:0] sz, logic [31:0] wd);
    if (sz == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  // w = BUSY cycle index (0-based) on which mem_ready rises; w >= TMO never answers.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int w, input logic [31:0] rd);
    bit mis, tmo, got;
    int exp_c, nstall, nen, bi, c;
    mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    tmo = !mis && (w >= TMO);
    exp_c = mis ? 1 : (tmo ? TMO + 1 : w + 2);
    nstall = 0; nen = 0; bi = 0; got = 0;
    @(negedge clock);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd; mem_rdata = rd;
    for (c = 0; c < 60; c++) begin
      #1;
      if (stall) nstall++;
      if (mem_en) begin
        nen++;
        if (bi == 0) begin
          chk("mem_we", mem_we, wr);
          chk("mem_be", mem_be, model_be(sz, a[1:0]));
          chk("mem_addr", mem_addr, a / 4);
          if (wr) chk("mem_wdata", mem_wdata, model_wd(sz, wd));
        end
        mem_ready = (bi == w);
        bi++;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      if (resp_valid) begin
        got = 1;
        break;
      end
      @(negedge clock);
    end
    chk("resp_seen", got, 1);
    chk("resp_cycle", c, exp_c);
    chk("stall_cycles", nstall, exp_c);
    chk("mem_en_cycles", nen, mis ? 0 : (tmo ? TMO : w + 1));
    chk("misalign_err", misalign_err, mis);
    chk("timeout_err", timeout_err, tmo);
    if (mis || tmo) exp_ld = 32'b0;
    else if (!wr)   exp_ld = model_load(rd, a[1:0], sz, uns);
    chk("load_data", load_data, exp_ld);
    req_valid = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    req_valid = 1'b1;
    #12;
    chk("rst_stall", stall, 0);
    chk("rst_resp", resp_valid, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_be", mem_be, 0);
    req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    do_req(1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 0, 32'h0);
    do_req(0, 2'd0, 0, 32'h203, 32'h0, 0, 32'h80FF_1234);
    do_req(0, 2'd0, 1, 32'h203, 32'h0, 0, 32'h80FF_1234);
    do_req(0, 2'd1, 0, 32'h12, 32'h0, 3, 32'h9ABC_0000);
    do_req(0, 2'd2, 0, 32'h102, 32'h0, 0, 32'h1111_1111);
    do_req(0, 2'd0, 0, 32'h7, 32'h0, 0, 32'h7F00_0000);
    do_req(0, 2'd2, 0, 32'h40, 32'h0, 99, 32'h5555_5555);

    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2;
    req_addr = 32'h300; req_wdata = 32'hCAFE_F00D; mem_ready = 1'b0;
    @(negedge clock); #1;
    chk("mid_rst_pre_en", mem_en, 1);
    #2; reset = 1'b0; #1;
    chk("mid_rst_mem_en", mem_en, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_resp", resp_valid, 0);
    chk("mid_rst_load_data", load_data, 0);
    exp_ld = 32'b0;
    @(negedge clock);
    reset = 1'b1; req_valid = 1'b0;
    repeat (4) begin
      @(negedge clock); #1;
      chk("post_rst_resp", resp_valid, 0);
      chk("post_rst_mem_en", mem_en, 0);
    end
    do_req(1, 2'd0, 0, 32'h1, 32'h1234_5678, 0, 32'h0);

    repeat (80) begin
      logic [1:0]  sz;
      logic [31:0] a;
      int w;
      sz = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      w = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, w, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
